// File: rtl/period_meter.sv
// Period / high-time meter for a single-bit waveform with lock and timeout flags.
// Optional input synchronizer: define PERIOD_METER_SYNC_EN.
module period_meter #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX       = '1;
    localparam int               MW        = $clog2(LOCK_N);
    localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_N - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state_q;
    logic             sig_s;
    logic             sig_d_q;
    logic             rise_d;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             meas_valid_q;
    logic             locked_q;
    logic             timeout_q;
    logic [MW-1:0]    match_q;
    logic             have_ref_q;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sig_in};
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig_in;
`endif

    assign rise_d = sig_s & ~sig_d_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            sig_d_q      <= 1'b1;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            match_q      <= '0;
            have_ref_q   <= 1'b0;
        end else begin
            sig_d_q      <= sig_s;
            meas_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise_d) begin
                        state_q    <= MEASURE;
                        per_cnt_q  <= CNT_W'(1);
                        hi_cnt_q   <= CNT_W'(1);
                        have_ref_q <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise_d) begin
                        period_q     <= per_cnt_q;
                        high_time_q  <= hi_cnt_q;
                        meas_valid_q <= 1'b1;
                        timeout_q    <= 1'b0;
                        per_cnt_q    <= CNT_W'(1);
                        hi_cnt_q     <= CNT_W'(1);
                        have_ref_q   <= 1'b1;
                        // First result after IDLE only seeds the comparison.
                        if (!have_ref_q || per_cnt_q != period_q) begin
                            match_q  <= '0;
                            locked_q <= 1'b0;
                        end else if (match_q == MATCH_MAX) begin
                            locked_q <= 1'b1;
                        end else begin
                            match_q <= match_q + 1'b1;
                        end
                    end else if (per_cnt_q == MAX) begin
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        match_q   <= '0;
                        state_q   <= IDLE;
                    end else begin
                        per_cnt_q <= per_cnt_q + 1'b1;
                        if (sig_s) begin
                            hi_cnt_q <= hi_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed testbench for period_meter (CNT_W = 8, LOCK_N = 4, no input synchronizer).
module tb_period_meter;

    logic       clk;
    logic       reset;
    logic       sig_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       locked;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    period_meter #(.CNT_W(8), .LOCK_N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample; outputs are observed 1 ns after the edge that sampled it.
    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk);
        #1;
    endtask

    // One waveform cycle: hi high samples then lo low samples. Returns outputs
    // seen right after the rising sample, and meas_valid pulses seen elsewhere.
    task automatic period_wave(input int hi, input int lo,
                               output logic mv, output logic [7:0] p,
                               output logic [7:0] h, output logic lk,
                               output logic to, output int extra);
        extra = 0;
        step(1'b1);
        mv = meas_valid; p = period; h = high_time; lk = locked; to = timeout;
        for (int i = 1; i < hi; i++) begin
            step(1'b1);
            if (meas_valid) extra++;
        end
        for (int i = 0; i < lo; i++) begin
            step(1'b0);
            if (meas_valid) extra++;
        end
    endtask

    task automatic test_reset();
        logic v;
        reset = 1'b0;
        v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(v);
            v = ~v;
            checks++;
            if ({period, high_time, meas_valid, locked, timeout} !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got p=%0d h=%0d mv=%b lk=%b to=%b, want all 0",
                         i, period, high_time, meas_valid, locked, timeout);
            end
        end
        reset = 1'b1;
        step(1'b1);
        checks++;
        if (meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_no_rise: got mv=%b want 0", meas_valid);
        end
        step(1'b1);
        step(1'b0);
        step(1'b0);
    endtask

    task automatic test_pattern();
        logic mv, lk, to;
        logic [7:0] p, h;
        int extra;
        for (int w = 0; w < 8; w++) begin
            period_wave(2, 3, mv, p, h, lk, to, extra);
            checks++;
            if (w == 0) begin
                if (mv !== 1'b0) begin
                    errors++;
                    $display("FAIL pattern_first_rise: got mv=%b want 0", mv);
                end
            end else if (mv !== 1'b1 || p !== 8'd5 || h !== 8'd2) begin
                errors++;
                $display("FAIL pattern_meas w=%0d: got mv=%b p=%0d h=%0d, want mv=1 p=5 h=2", w, mv, p, h);
            end
            checks++;
            if (lk !== (w >= 5)) begin
                errors++;
                $display("FAIL pattern_locked w=%0d: got %b want %b", w, lk, (w >= 5));
            end
            checks++;
            if (extra !== 0) begin
                errors++;
                $display("FAIL pattern_extra_mv w=%0d: got %0d pulses want 0", w, extra);
            end
        end
    endtask

    task automatic test_relock();
        logic mv, lk, to;
        logic [7:0] p, h;
        int extra;
        logic [7:0] exp_p;
        logic [7:0] exp_h;
        for (int w = 0; w < 7; w++) begin
            period_wave(3, 4, mv, p, h, lk, to, extra);
            exp_p = (w == 0) ? 8'd5 : 8'd7;
            exp_h = (w == 0) ? 8'd2 : 8'd3;
            checks++;
            if (mv !== 1'b1 || p !== exp_p || h !== exp_h) begin
                errors++;
                $display("FAIL relock_meas w=%0d: got mv=%b p=%0d h=%0d, want mv=1 p=%0d h=%0d",
                         w, mv, p, h, exp_p, exp_h);
            end
            checks++;
            if (lk !== (w == 0 || w >= 5)) begin
                errors++;
                $display("FAIL relock_locked w=%0d: got %b want %b", w, lk, (w == 0 || w >= 5));
            end
        end
    endtask

    task automatic test_timeout();
        logic mv, lk, to;
        logic [7:0] p, h;
        int extra;
        int early;
        early = 0;
        step(1'b1);
        for (int n = 1; n < 255; n++) begin
            step(1'b0);
            if (timeout !== 1'b0 || meas_valid !== 1'b0) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL timeout_early: got %0d bad cycles want 0", early);
        end
        step(1'b0);
        checks++;
        if (timeout !== 1'b1 || locked !== 1'b0 || meas_valid !== 1'b0 || period !== 8'd7) begin
            errors++;
            $display("FAIL timeout_assert: got to=%b lk=%b mv=%b p=%0d, want to=1 lk=0 mv=0 p=7",
                     timeout, locked, meas_valid, period);
        end
        step(1'b0);
        period_wave(2, 3, mv, p, h, lk, to, extra);
        checks++;
        if (mv !== 1'b0 || to !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle_rise: got mv=%b to=%b want mv=0 to=1", mv, to);
        end
        period_wave(2, 3, mv, p, h, lk, to, extra);
        checks++;
        if (mv !== 1'b1 || to !== 1'b0 || p !== 8'd5 || lk !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got mv=%b to=%b p=%0d lk=%b, want mv=1 to=0 p=5 lk=0", mv, to, p, lk);
        end
    endtask

    task automatic test_boundary();
        step(1'b1);
        for (int n = 1; n < 255; n++) step(1'b0);
        step(1'b1);
        checks++;
        if (meas_valid !== 1'b1 || period !== 8'd255 || high_time !== 8'd1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL boundary_255: got mv=%b p=%0d h=%0d to=%b, want mv=1 p=255 h=1 to=0",
                     meas_valid, period, high_time, timeout);
        end
        for (int n = 1; n < 255; n++) step(1'b0);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL boundary_256_early: got to=%b want 0", timeout);
        end
        step(1'b0);
        step(1'b1);
        checks++;
        if (meas_valid !== 1'b0 || timeout !== 1'b1 || period !== 8'd255) begin
            errors++;
            $display("FAIL boundary_256: got mv=%b to=%b p=%0d, want mv=0 to=1 p=255", meas_valid, timeout, period);
        end
        step(1'b0);
    endtask

    task automatic test_reset_mid();
        logic mv, lk, to;
        logic [7:0] p, h;
        int extra;
        reset = 1'b0;
        step(1'b0);
        reset = 1'b1;
        step(1'b0);
        for (int w = 0; w < 6; w++) period_wave(2, 3, mv, p, h, lk, to, extra);
        checks++;
        if (lk !== 1'b1) begin
            errors++;
            $display("FAIL midreset_prelock: got lk=%b want 1", lk);
        end
        step(1'b1);
        step(1'b1);
        reset = 1'b0;
        step(1'b0);
        checks++;
        if ({period, high_time, meas_valid, locked, timeout} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got p=%0d h=%0d mv=%b lk=%b to=%b, want all 0",
                     period, high_time, meas_valid, locked, timeout);
        end
        reset = 1'b1;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        period_wave(2, 3, mv, p, h, lk, to, extra);
        checks++;
        if (mv !== 1'b0) begin
            errors++;
            $display("FAIL midreset_first_rise: got mv=%b want 0", mv);
        end
        period_wave(2, 3, mv, p, h, lk, to, extra);
        checks++;
        if (mv !== 1'b1 || p !== 8'd5 || h !== 8'd2 || lk !== 1'b0) begin
            errors++;
            $display("FAIL midreset_remeasure: got mv=%b p=%0d h=%0d lk=%b, want mv=1 p=5 h=2 lk=0", mv, p, h, lk);
        end
    endtask

    initial begin
        reset  = 1'b0;
        sig_in = 1'b0;
        test_reset();
        test_pattern();
        test_relock();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
